// File: rtl/seq_adder_pkg.sv
// Shared definitions for the multi-byte sequential adder.
//   - BYTE_W            : width of one datapath byte
//   - DEFAULT_NUM_BYTES : default operand width in bytes
//   - MAX_NUM_BYTES     : largest supported operand width in bytes
//   - state_e           : control FSM encoding (idle / run / done)
//   - byte_lsb()        : bit offset of a byte lane inside a packed operand
package seq_adder_pkg;

  localparam int unsigned BYTE_W            = 8;
  localparam int unsigned DEFAULT_NUM_BYTES = 4;
  localparam int unsigned MAX_NUM_BYTES     = 16;
  // Wide enough to index every lane up to MAX_NUM_BYTES.
  localparam int unsigned IDX_W_MAX         = 4;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  function automatic int unsigned byte_lsb(input logic [IDX_W_MAX-1:0] idx);
    return BYTE_W * 32'(idx);
  endfunction

endpackage

// File: rtl/eight_bit_hybrid_adder.sv
// Combinational 8-bit adder used as the byte datapath of the sequential adder.
// The low nibble ripples; the high nibble is computed for both possible carries
// and the real one selects the result (carry-select), shortening the carry path.
//
// Ports:
//   a, b    : 8-bit addends
//   cy_in   : carry into bit 0
//   sum     : 8-bit result
//   cy_out  : carry out of bit 7
module eight_bit_hybrid_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cy_in,
  output logic [7:0] sum,
  output logic       cy_out
);

  // {carry_out, sum[3:0]} of a 4-bit ripple-carry add.
  function automatic logic [4:0] ripple4(input logic [3:0] x, input logic [3:0] y,
                                         input logic ci);
    logic [4:0] c;
    logic [3:0] s;
    c[0] = ci;
    for (int i = 0; i < 4; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
    end
    return {c[4], s};
  endfunction

  logic [4:0] lo_res;
  logic [4:0] hi_res_c0;
  logic [4:0] hi_res_c1;

  assign lo_res    = ripple4(a[3:0], b[3:0], cy_in);
  assign hi_res_c0 = ripple4(a[7:4], b[7:4], 1'b0);
  assign hi_res_c1 = ripple4(a[7:4], b[7:4], 1'b1);

  always_comb begin
    sum[3:0] = lo_res[3:0];
    if (lo_res[4]) begin
      sum[7:4] = hi_res_c1[3:0];
      cy_out   = hi_res_c1[4];
    end else begin
      sum[7:4] = hi_res_c0[3:0];
      cy_out   = hi_res_c0[4];
    end
  end

endmodule

// File: rtl/multi_byte_sequential_adder.sv
// Multi-byte sequential adder: adds two NUM_BYTES-byte unsigned operands plus a
// carry-in one byte per clock (LSB byte first) through a single 8-bit adder.
// A start in idle latches the operands; NUM_BYTES cycles later done pulses for
// one cycle and sum/cy_out hold until the next accepted start.
//
// Optional build macro:
//   SEQ_ADDER_OVERFLOW_EN : adds output ovf, the signed-overflow flag of the
//                           final byte (carry into MSB xor carry out of MSB).
//
// Ports:
//   clk    : clock, rising edge active
//   rst_n  : asynchronous active-low reset
//   start  : begin an add; only honoured in idle
//   a, b   : operands, sampled on the accepting edge
//   cy_in  : carry into byte 0, sampled on the accepting edge
//   busy   : high while bytes are being added
//   done   : one-cycle pulse, result valid
//   sum    : registered result
//   cy_out : registered carry out of the top byte
//   ovf    : registered signed overflow (only with SEQ_ADDER_OVERFLOW_EN)
module multi_byte_sequential_adder
  import seq_adder_pkg::*;
#(
  parameter int unsigned NUM_BYTES = DEFAULT_NUM_BYTES
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [8*NUM_BYTES-1:0]      a,
  input  logic [8*NUM_BYTES-1:0]      b,
  input  logic                        cy_in,
  output logic                        busy,
  output logic                        done,
  output logic [8*NUM_BYTES-1:0]      sum,
  output logic                        cy_out
`ifdef SEQ_ADDER_OVERFLOW_EN
  ,
  output logic                        ovf
`endif
);

  localparam int unsigned DataW = NUM_BYTES * BYTE_W;
  localparam int unsigned IdxW  = (NUM_BYTES > 2) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_BYTES - 1);

  state_e state_q, state_d;

  logic [DataW-1:0] op_a_q, op_a_d;
  logic [DataW-1:0] op_b_q, op_b_d;
  logic [DataW-1:0] sum_q, sum_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cy_out_q, cy_out_d;
`ifdef SEQ_ADDER_OVERFLOW_EN
  logic             ovf_q, ovf_d;
  logic             msb_carry_in;
`endif

  logic [BYTE_W-1:0] byte_a;
  logic [BYTE_W-1:0] byte_b;
  logic [BYTE_W-1:0] byte_sum;
  logic              byte_cy;
  logic              last_byte;
  int unsigned       lane_lsb;

  assign last_byte = (idx_q == LastIdx);
  assign lane_lsb  = byte_lsb(IDX_W_MAX'(idx_q));
  assign byte_a    = op_a_q[lane_lsb +: BYTE_W];
  assign byte_b    = op_b_q[lane_lsb +: BYTE_W];

  eight_bit_hybrid_adder u_byte_adder (
    .a      (byte_a),
    .b      (byte_b),
    .cy_in  (carry_q),
    .sum    (byte_sum),
    .cy_out (byte_cy)
  );

`ifdef SEQ_ADDER_OVERFLOW_EN
  // Carry into the MSB of the lane, recovered from the sum bit.
  assign msb_carry_in = byte_a[BYTE_W-1] ^ byte_b[BYTE_W-1] ^ byte_sum[BYTE_W-1];
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (last_byte) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      StRun:   busy = 1'b1;
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------------
  always_comb begin
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    sum_d    = sum_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    cy_out_d = cy_out_q;
`ifdef SEQ_ADDER_OVERFLOW_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          op_a_d   = a;
          op_b_d   = b;
          sum_d    = '0;
          idx_d    = '0;
          carry_d  = cy_in;
          cy_out_d = 1'b0;
`ifdef SEQ_ADDER_OVERFLOW_EN
          ovf_d    = 1'b0;
`endif
        end
      end
      StRun: begin
        sum_d[lane_lsb +: BYTE_W] = byte_sum;
        carry_d                   = byte_cy;
        if (last_byte) begin
          // Park the index at 0 so it never points past the top lane.
          idx_d    = '0;
          cy_out_d = byte_cy;
`ifdef SEQ_ADDER_OVERFLOW_EN
          ovf_d    = msb_carry_in ^ byte_cy;
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q   <= '0;
      op_b_q   <= '0;
      sum_q    <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      cy_out_q <= 1'b0;
`ifdef SEQ_ADDER_OVERFLOW_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      sum_q    <= sum_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      cy_out_q <= cy_out_d;
`ifdef SEQ_ADDER_OVERFLOW_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign sum    = sum_q;
  assign cy_out = cy_out_q;
`ifdef SEQ_ADDER_OVERFLOW_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_multi_byte_sequential_adder.sv
// Self-checking bench for multi_byte_sequential_adder with NUM_BYTES = 4.
// A timestamp model predicts busy/done/sum/cy_out (and ovf when
// SEQ_ADDER_OVERFLOW_EN is defined) from the accept edge and plain integer
// addition; a compare process checks it every falling edge. Directed vectors
// add literal expectations for result, latency and busy length.
module tb_multi_byte_sequential_adder;

  localparam int unsigned NB = 4;
  localparam int unsigned W  = 8 * NB;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         cy_in = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cy_out;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  multi_byte_sequential_adder #(
    .NUM_BYTES (NB)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .cy_in  (cy_in),
    .busy   (busy),
    .done   (done),
    .sum    (sum),
    .cy_out (cy_out)
`ifdef SEQ_ADDER_OVERFLOW_EN
    ,
    .ovf    (ovf)
`endif
  );

`ifndef SEQ_ADDER_OVERFLOW_EN
  assign ovf = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: remembers the edge on which an add was accepted and its full result.
  // Age = edges since accept: 0..NB-1 busy, NB done, beyond that idle.
  // ---------------------------------------------------------------------------
  int unsigned  edge_cnt = 0;
  int unsigned  acc_edge = 0;
  bit           have_op  = 1'b0;
  logic [W:0]   res      = '0;
  logic         m_ovf    = 1'b0;

  function automatic bit model_idle();
    return !have_op || ((edge_cnt - acc_edge) >= NB + 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [W:0] r;
    if (!rst_n) begin
      have_op <= 1'b0;
    end else begin
      edge_cnt <= edge_cnt + 1;
      if (start && model_idle()) begin
        r        = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cy_in};
        have_op  <= 1'b1;
        acc_edge <= edge_cnt + 1;
        res      <= r;
        m_ovf    <= r[W] ^ (a[W-1] ^ b[W-1] ^ r[W-1]);
      end
    end
  end

  always @(negedge clk) begin
    int unsigned age;
    age = edge_cnt - acc_edge;
    check("model busy", 64'(busy), 64'(have_op && (age < NB)));
    check("model done", 64'(done), 64'(have_op && (age == NB)));
    if (!have_op) begin
      check("model sum idle", 64'(sum), 64'd0);
      check("model cy_out idle", 64'(cy_out), 64'd0);
`ifdef SEQ_ADDER_OVERFLOW_EN
      check("model ovf idle", 64'(ovf), 64'd0);
`endif
    end else if (age >= NB) begin
      check("model sum", 64'(sum), 64'(res[W-1:0]));
      check("model cy_out", 64'(cy_out), 64'(res[W]));
`ifdef SEQ_ADDER_OVERFLOW_EN
      check("model ovf", 64'(ovf), 64'(m_ovf));
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Directed add: request, wait for accept, scramble inputs, wait for done.
  // ---------------------------------------------------------------------------
  task automatic run_add(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tc, input logic [W-1:0] xs, input logic xc,
                         input logic xo, input bit disturb);
    int c;
    int busy_n;
    @(negedge clk);
    a = ta; b = tb; cy_in = tc; start = 1'b1;
    c = 0;
    @(negedge clk);
    while (!busy && c < 10) begin
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    a = ~ta; b = ta ^ tb; cy_in = ~tc;
    check({name, " accepted"}, 64'(busy), 64'd1);
    if (!busy) return;
    busy_n = 0;
    c = 0;
    while (!done && c < 20) begin
      busy_n += int'(busy);
      if (disturb && c == 1) begin
        start = 1'b1; a = 32'hAAAA_5555; b = 32'h5555_AAAA; cy_in = 1'b1;
      end
      if (disturb && c == 2) begin
        start = 1'b0; a = '0; b = '0;
      end
      @(negedge clk);
      c++;
    end
    check({name, " latency"}, 64'(c), 64'(NB));
    check({name, " busy cycles"}, 64'(busy_n), 64'(NB));
    check({name, " sum"}, 64'(sum), 64'(xs));
    check({name, " cy_out"}, 64'(cy_out), 64'(xc));
`ifdef SEQ_ADDER_OVERFLOW_EN
    check({name, " ovf"}, 64'(ovf), 64'(xo));
`else
    if (xo !== 1'bx) check({name, " ovf absent"}, 64'(ovf), 64'd0);
`endif
    repeat (2) @(negedge clk);
    check({name, " sum held"}, 64'(sum), 64'(xs));
    check({name, " done single"}, 64'(done), 64'd0);
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset sum", 64'(sum), 64'd0);
    check("reset cy_out", 64'(cy_out), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post-reset idle sum", 64'(sum), 64'd0);
    check("post-reset idle busy", 64'(busy), 64'd0);

    run_add("ff+1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    run_add("ffffffff+0+c", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0,
            1'b0);
    run_add("disturbed", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0,
            1'b1);
    run_add("deadbeef", 32'hDEAD_BEEF, 32'h2152_4111, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    run_add("8000+8000+c", 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0001, 1'b1, 1'b1,
            1'b0);
    run_add("7fffffff+1", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_add("ffffffff+1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of an add, when idx has reached 2.
    @(negedge clk);
    a = 32'h0102_0304; b = 32'h1010_1010; cy_in = 1'b0; start = 1'b1;
    begin
      int c;
      c = 0;
      @(negedge clk);
      while (!busy && c < 10) begin
        @(negedge clk);
        c++;
      end
    end
    start = 1'b0;
    check("mid-run accepted", 64'(busy), 64'd1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async reset busy", 64'(busy), 64'd0);
    check("async reset done", 64'(done), 64'd0);
    check("async reset sum", 64'(sum), 64'd0);
    check("async reset cy_out", 64'(cy_out), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("after reset no done", 64'(done), 64'd0);
    run_add("1+1 after reset", 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0,
            1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_byte_sequential_adder.md
MULTI_BYTE_SEQUENTIAL_ADDER -- requirements
Module: multi_byte_sequential_adder

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 4, giving the operand width in bytes (range 2..16).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request to begin an add; sampled only in IDLE.
REQ-005 SHALL have port a, input, 8*NUM_BYTES, first operand; sampled on the accepting edge.
REQ-006 SHALL have port b, input, 8*NUM_BYTES, second operand; sampled on the accepting edge.
REQ-007 SHALL have port cy_in, input, 1, carry into byte 0; sampled on the accepting edge.
REQ-008 SHALL have port busy, output, 1, high while in RUN.
REQ-009 SHALL have port done, output, 1, single-cycle pulse marking the result as valid.
REQ-010 SHALL have port sum, output, 8*NUM_BYTES, registered result.
REQ-011 SHALL have port cy_out, output, 1, registered carry out of the top byte.

Function
REQ-012 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-013 In IDLE with start=1, SHALL latch a, b and cy_in into operand and carry registers, clear the byte index and sum, then enter RUN.
REQ-014 In RUN, each cycle SHALL add operand byte[idx] of a and b plus the carry register through one 8-bit adder, write sum byte[idx], update the carry register and increment idx (LSB byte first).
REQ-015 After the byte at idx=NUM_BYTES-1 is written, SHALL load cy_out from the final carry and enter DONE.
REQ-016 In DONE, SHALL assert done for exactly one cycle, then return to IDLE unconditionally.
REQ-017 Latency: for start accepted at edge k, done SHALL be high between edges k+NUM_BYTES and k+NUM_BYTES+1.
REQ-018 sum and cy_out SHALL hold their values from DONE until the next accepting edge.
REQ-019 start while in RUN or DONE SHALL be ignored, with no queuing and no effect on the add in progress.
REQ-020 Changes to a, b or cy_in after the accepting edge SHALL NOT affect the result.
REQ-021 Arithmetic SHALL be unsigned modulo 2^(8*NUM_BYTES), with the carry exported only via cy_out.
REQ-022 busy SHALL be 1 exactly in RUN, and done SHALL be 1 exactly in DONE.

Reset
REQ-023 rst_n=0 SHALL force IDLE immediately and asynchronously, with busy=0, done=0, sum=0, cy_out=0, idx=0 and carry register 0.
REQ-024 Reset asserted mid-RUN SHALL abandon the operation with no done pulse; the first start after deassertion SHALL behave as from power-up.

Configuration
REQ-025 With SEQ_ADDER_OVERFLOW_EN defined, SHALL provide output ovf, 1 bit, equal to (carry into MSB bit) XOR (carry out of MSB bit) of the final byte, registered alongside cy_out, reset to 0 and held like sum.
REQ-026 Without SEQ_ADDER_OVERFLOW_EN, the ovf port and its logic SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-027 A shared package seq_adder_pkg SHALL hold the FSM state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10), the BYTE_W=8 constant and the default NUM_BYTES.
REQ-028 The byte datapath SHALL be one instance of the existing eight_bit_hybrid_adder (a, b, cy_in, sum, cy_out), with no other sub-modules.

Verification (NUM_BYTES=4)
REQ-029 Hold rst_n=0 -> busy=0, done=0, sum=0x00000000, cy_out=0; release with start=0 -> outputs stay 0.
REQ-030 Start with a=0x000000FF, b=0x00000001, cy_in=0 -> done high in the 4th cycle after the accepting edge, sum=0x00000100, cy_out=0.
REQ-031 Start with a=0xFFFFFFFF, b=0x00000000, cy_in=1 -> sum=0x00000000, cy_out=1, busy high for exactly 4 cycles.
REQ-032 Start with a=0x12345678, b=0x11111111, pulse start again with other operands during RUN, and change a/b mid-RUN -> single done, sum=0x23456789, cy_out=0.
REQ-033 Assert rst_n=0 at idx=2 -> immediate IDLE, all outputs 0, no done; then start with 0x00000001+0x00000001 -> sum=0x00000002.
REQ-034 With SEQ_ADDER_OVERFLOW_EN: 0x7FFFFFFF+0x00000001, cy_in=0 -> sum=0x80000000, cy_out=0, ovf=1; 0xFFFFFFFF+0x00000001 -> ovf=0, cy_out=1.
